// File: rtl/pmu_sched.sv
// Job-level round-robin scheduler sharing one pmu multiply datapath between two requesters.
// A tag pipeline tracks the fixed pmu latency; results leave through a credit-protected FIFO.
module pmu_sched #(
    parameter int NUM_LANES  = 240,
    parameter int DATA_WIDTH = 16,
    parameter int PMU_LAT    = 2,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [1:0]                           s_valid,
    output logic [1:0]                           s_ready,
    input  logic [2*LEN_W-1:0]                   s_len,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]      s_a0_flat,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]      s_b0_flat,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]      s_a1_flat,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]      s_b1_flat,
    output logic [NUM_LANES*DATA_WIDTH-1:0]      pmu_a_flat,
    output logic [NUM_LANES*DATA_WIDTH-1:0]      pmu_b_flat,
    input  logic [NUM_LANES*(DATA_WIDTH+1)-1:0]  pmu_p_flat,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [NUM_LANES*(DATA_WIDTH+1)-1:0]  m_p_flat,
    output logic                                 m_id,
    output logic                                 m_last,
    output logic                                 busy
);

    localparam int P_W   = NUM_LANES * (DATA_WIDTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + PMU_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic           id;
        logic           last;
        logic [P_W-1:0] p;
    } entry_t;

    state_t             state, state_nxt;
    logic               owner;
    logic               last_grant;
    logic               grant_id;
    logic [LEN_W-1:0]   remaining;
    logic               issue;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   credit_used;

    logic [PMU_LAT-1:0] tag_valid;
    logic [PMU_LAT-1:0] tag_id;
    logic [PMU_LAT-1:0] tag_last;

    entry_t             fifo_mem [FIFO_DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               push, pop;

    // Round-robin: on a tie the requester not granted last time wins.
    assign grant_id = s_valid[1] && (!s_valid[0] || !last_grant);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|s_valid) state_nxt = BUSY;
            BUSY:    if (issue && remaining == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Credit counts are registered, so a pop in this cycle frees space only next cycle.
    assign credit_used = fifo_count + inflight;

    always_comb begin
        issue   = (state == BUSY) && s_valid[owner] && (credit_used < CNT_W'(FIFO_DEPTH));
        s_ready = 2'b00;
        if (issue) s_ready = owner ? 2'b10 : 2'b01;
    end

    // Job bookkeeping: owner/length latched in the grant cycle, counted down per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            remaining  <= '0;
        end else if (state == IDLE && |s_valid) begin
            owner      <= grant_id;
            last_grant <= grant_id;
            remaining  <= grant_id ? s_len[2*LEN_W-1:LEN_W] : s_len[LEN_W-1:0];
        end else if (issue) begin
            remaining  <= remaining - LEN_W'(1);
        end
    end

    assign pmu_a_flat = owner ? s_a1_flat : s_a0_flat;
    assign pmu_b_flat = owner ? s_b1_flat : s_b0_flat;

    // Tag pipeline mirrors the pmu latency; only valid tags turn products into results.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_id[0]    <= owner;
            tag_last[0]  <= (remaining == '0);
            for (int i = 1; i < PMU_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PMU_LAT; i++) inflight = inflight + CNT_W'(tag_valid[i]);
    end

    // ---------------- Result FIFO ----------------
    assign push = tag_valid[PMU_LAT-1];
    assign pop  = m_valid && m_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: the storage array is not reset; fifo_count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{id: tag_id[PMU_LAT-1], last: tag_last[PMU_LAT-1], p: pmu_p_flat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Outputs are forced to zero while empty so stale storage never shows.
    assign head     = fifo_mem[rd_ptr];
    assign m_valid  = (fifo_count != '0);
    assign m_p_flat = m_valid ? head.p    : '0;
    assign m_id     = m_valid ? head.id   : 1'b0;
    assign m_last   = m_valid ? head.last : 1'b0;
    assign busy     = (state == BUSY) || (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_pmu_sched.sv
// Self-checking bench for pmu_sched: cycle tables for the basic job, plus randomized traffic
// checked against a job-level scoreboard built from the arbitration and credit rules.
module tb_pmu_sched;

    localparam int NUM_LANES  = 240;
    localparam int DATA_WIDTH = 16;
    localparam int PMU_LAT    = 2;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int OP_W       = NUM_LANES * DATA_WIDTH;
    localparam int PL         = DATA_WIDTH + 1;
    localparam int P_W        = NUM_LANES * PL;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         s_valid, s_ready;
    logic [2*LEN_W-1:0] s_len;
    logic [OP_W-1:0]    s_a0_flat, s_b0_flat, s_a1_flat, s_b1_flat, pmu_a_flat, pmu_b_flat;
    logic [P_W-1:0]     pmu_p_flat, m_p_flat;
    logic               m_valid, m_ready, m_id, m_last, busy;

    pmu_sched #(
        .NUM_LANES(NUM_LANES), .DATA_WIDTH(DATA_WIDTH), .PMU_LAT(PMU_LAT),
        .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_len(s_len),
        .s_a0_flat(s_a0_flat), .s_b0_flat(s_b0_flat), .s_a1_flat(s_a1_flat), .s_b1_flat(s_b1_flat),
        .pmu_a_flat(pmu_a_flat), .pmu_b_flat(pmu_b_flat), .pmu_p_flat(pmu_p_flat),
        .m_valid(m_valid), .m_ready(m_ready), .m_p_flat(m_p_flat), .m_id(m_id),
        .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural pmu: lane-wise product truncated to DATA_WIDTH+1 bits, PMU_LAT stages deep.
    function automatic logic [P_W-1:0] pmu_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        logic [P_W-1:0] r;
        logic [31:0]    prod;
        for (int l = 0; l < NUM_LANES; l++) begin
            prod = 32'(a[l*DATA_WIDTH +: DATA_WIDTH]) * 32'(b[l*DATA_WIDTH +: DATA_WIDTH]);
            r[l*PL +: PL] = prod[PL-1:0];
        end
        return r;
    endfunction

    logic [P_W-1:0] pmu_pipe [PMU_LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PMU_LAT; i++) pmu_pipe[i] <= '0;
        end else begin
            pmu_pipe[0] <= pmu_mul(pmu_a_flat, pmu_b_flat);
            for (int i = 1; i < PMU_LAT; i++) pmu_pipe[i] <= pmu_pipe[i-1];
        end
    end
    assign pmu_p_flat = pmu_pipe[PMU_LAT-1];

    // ---------------- Checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Reference model state ----------------
    typedef struct {
        logic           id;
        logic           last;
        logic [P_W-1:0] p;
        int             t;
    } exp_t;

    exp_t            sbq[$];
    int              acc_cyc[$];
    int              job_order[$];
    int              job_len[2], done[2], jobs_left[2];
    bit              active[2];
    bit              own_busy, hold0;
    int              own_id, cyc;
    int              cfg_fixed, cfg_max;
    logic [OP_W-1:0] a_r[2], b_r[2];

    function automatic logic [P_W-1:0] ref_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        logic [P_W-1:0] r;
        int unsigned    x, y;
        for (int l = 0; l < NUM_LANES; l++) begin
            x = 32'(a[l*DATA_WIDTH +: DATA_WIDTH]);
            y = 32'(b[l*DATA_WIDTH +: DATA_WIDTH]);
            r[l*PL +: PL] = PL'((x * y) % 32'h20000);
        end
        return r;
    endfunction

    function automatic logic [OP_W-1:0] rand_vec();
        logic [OP_W-1:0] v;
        for (int l = 0; l < NUM_LANES; l++) begin
            case ($urandom_range(0, 7))
                0:       v[l*DATA_WIDTH +: DATA_WIDTH] = 16'hFFFF;
                1:       v[l*DATA_WIDTH +: DATA_WIDTH] = 16'h8000;
                2:       v[l*DATA_WIDTH +: DATA_WIDTH] = 16'h0000;
                default: v[l*DATA_WIDTH +: DATA_WIDTH] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    function automatic int next_len();
        return (cfg_fixed != 0) ? cfg_fixed : int'($urandom_range(1, cfg_max));
    endfunction

    task automatic start_job(input int r, input int len, input int n);
        active[r]    = 1'b1;
        job_len[r]   = len;
        done[r]      = 0;
        jobs_left[r] = n;
    endtask

    task automatic reset_all();
        rst = 1'b1; s_valid = 2'b00; m_ready = 1'b0; s_len = '0;
        s_a0_flat = '0; s_b0_flat = '0; s_a1_flat = '0; s_b1_flat = '0;
        step();
        step();
        rst = 1'b0;
        sbq.delete(); acc_cyc.delete(); job_order.delete();
        for (int r = 0; r < 2; r++) begin
            active[r] = 1'b0; done[r] = 0; jobs_left[r] = 0; job_len[r] = 1;
        end
        own_busy = 1'b0; own_id = 0; hold0 = 1'b0; cyc = 0;
    endtask

    // Called at the falling edge: handshakes seen now complete at the next rising edge.
    task automatic sample(input bit strict);
        exp_t e;
        int   bad;
        check("s_ready_onehot", 64'(s_ready & (s_ready - 2'd1)), 64'd0);
        if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_result", 64'(m_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("m_id", 64'(m_id), 64'(e.id));
                check("m_last", 64'(m_last), 64'(e.last));
                bad = 0;
                for (int l = NUM_LANES - 1; l >= 0; l--)
                    if (m_p_flat[l*PL +: PL] !== e.p[l*PL +: PL]) bad = l;
                check("m_p_lane", 64'(m_p_flat[bad*PL +: PL]), 64'(e.p[bad*PL +: PL]));
                if (strict) check("latency", 64'(cyc - e.t), 64'(PMU_LAT + 1));
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (s_valid[r] && s_ready[r]) begin
                check("owner", 64'(r), 64'(own_busy ? own_id : r));
                e.id   = 1'(r);
                e.last = (done[r] == job_len[r] - 1);
                e.p    = ref_mul(a_r[r], b_r[r]);
                e.t    = cyc;
                sbq.push_back(e);
                acc_cyc.push_back(cyc);
                if (done[r] == 0) job_order.push_back(r);
                done[r]++;
                if (e.last) begin
                    own_busy = 1'b0;
                    jobs_left[r]--;
                    if (jobs_left[r] > 0) start_job(r, next_len(), jobs_left[r]);
                    else active[r] = 1'b0;
                end else begin
                    own_busy = 1'b1;
                    own_id   = r;
                end
            end
        end
    endtask

    task automatic run(input int ncyc, input int pv, input int pr, input bit strict);
        logic [1:0]       sv;
        logic [LEN_W-1:0] ln[2];
        for (int n = 0; n < ncyc; n++) begin
            for (int r = 0; r < 2; r++) begin
                a_r[r] = rand_vec();
                b_r[r] = rand_vec();
                sv[r]  = active[r] && ($urandom_range(0, 99) < pv) && !(r == 0 && hold0);
                // Once a job has started its length field is don't-care: feed junk.
                ln[r]  = (done[r] > 0) ? LEN_W'($urandom) : LEN_W'(job_len[r] - 1);
            end
            s_a0_flat = a_r[0]; s_b0_flat = b_r[0];
            s_a1_flat = a_r[1]; s_b1_flat = b_r[1];
            s_valid   = sv;
            s_len     = {ln[1], ln[0]};
            m_ready   = ($urandom_range(0, 99) < pr);
            @(negedge clk);
            sample(strict);
            step();
            cyc++;
        end
    endtask

    task automatic drain(input int budget, input bit strict);
        bit ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            run(1, 100, 100, strict);
            ok = !active[0] && !active[1] && (sbq.size() == 0) && !busy;
        end
        check("drain_complete", 64'(ok), 64'd1);
    endtask

    // ---------------- Cycle table for one 3-beat req0 job ----------------
    typedef struct {
        logic [1:0] sv;
        logic [1:0] rdy;
        logic       mv;
        logic       mid;
        logic       mlast;
        logic       bsy;
    } row_t;

    row_t tbl[8];

    task automatic run_table(input logic [15:0] a, input logic [15:0] b, input logic [PL-1:0] p);
        logic [P_W-1:0] exp_p;
        for (int i = 0; i < 8; i++) begin
            s_valid   = tbl[i].sv;
            s_len     = {8'd0, 8'd2};
            s_a0_flat = {NUM_LANES{a}};
            s_b0_flat = {NUM_LANES{b}};
            s_a1_flat = rand_vec();
            s_b1_flat = rand_vec();
            m_ready   = 1'b1;
            exp_p     = tbl[i].mv ? {NUM_LANES{p}} : '0;
            @(negedge clk);
            check($sformatf("tbl%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].rdy));
            check($sformatf("tbl%0d_m_valid", i), 64'(m_valid), 64'(tbl[i].mv));
            check($sformatf("tbl%0d_m_id", i), 64'(m_id), 64'(tbl[i].mid));
            check($sformatf("tbl%0d_m_last", i), 64'(m_last), 64'(tbl[i].mlast));
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
            check($sformatf("tbl%0d_m_p", i), 64'(m_p_flat == exp_p), 64'd1);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_acc[6];

        // cycle 0 = grant, 1..3 = beats, results 3 cycles after each accept
        tbl[0] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_acc = '{1, 2, 4, 5, 7, 8};
        cfg_fixed = 0; cfg_max = 6;

        // Reset state
        reset_all();
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_id", 64'(m_id), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_p", 64'(m_p_flat == '0), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        step();

        // Basic job and truncation corners
        run_table(16'd3, 16'd5, 17'd15);
        reset_all();
        run_table(16'hFFFF, 16'hFFFF, 17'h00001);
        reset_all();
        run_table(16'h8000, 16'd2, 17'h10000);

        // Credit stop with m_ready low, then a 1-cycle reset with 2 in flight and 2 queued
        reset_all();
        s_len = {8'd0, 8'd9}; s_valid = 2'b01; m_ready = 1'b0;
        s_a0_flat = {NUM_LANES{16'd3}}; s_b0_flat = {NUM_LANES{16'd5}};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("credit_c%0d", c), 64'(s_ready), (c >= 1) ? 64'd1 : 64'd0);
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        check("credit_c5", 64'(s_ready), 64'd0);
        check("pre_rst_m_valid", 64'(m_valid), 64'd1);
        step();
        rst = 1'b0;
        run_table(16'd3, 16'd5, 17'd15);

        // Round-robin with both requesters always valid, 2-beat jobs
        reset_all();
        cfg_fixed = 2;
        start_job(0, 2, 4);
        start_job(1, 2, 4);
        run(12, 100, 100, 1'b1);
        if (job_order.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 64'(job_order[i]), 64'(i % 2));
        end else begin
            check("rr_jobs", 64'(job_order.size()), 64'd4);
        end
        if (acc_cyc.size() >= 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("rr_accept%0d", i), 64'(acc_cyc[i]), 64'(exp_acc[i]));
        end else begin
            check("rr_accepts", 64'(acc_cyc.size()), 64'd6);
        end
        drain(50, 1'b1);

        // Req1 10-beat job against a stalled output, then release
        reset_all();
        cfg_fixed = 10;
        start_job(1, 10, 1);
        run(12, 100, 0, 1'b0);
        check("stall_accepts", 64'(acc_cyc.size()), 64'd4);
        run(20, 100, 100, 1'b0);
        check("stall_total", 64'(acc_cyc.size()), 64'd10);
        drain(50, 1'b0);

        // Owner bubble: req0 drops valid for 3 cycles while req1 waits
        reset_all();
        cfg_fixed = 2;
        start_job(0, 8, 1);
        start_job(1, 2, 1);
        run(3, 100, 100, 1'b1);
        hold0 = 1'b1;
        run(3, 100, 100, 1'b1);
        check("bubble_no_accept", 64'(acc_cyc.size()), 64'd2);
        hold0 = 1'b0;
        run(15, 100, 100, 1'b1);
        drain(50, 1'b1);
        check("bubble_jobs", 64'(job_order.size()), 64'd2);

        // Maximum-length job: 256 beats
        reset_all();
        cfg_fixed = 1;
        start_job(0, 256, 1);
        start_job(1, 1, 1);
        drain(400, 1'b1);
        check("maxlen_beats", 64'(acc_cyc.size()), 64'd257);

        // Random traffic: bubbles, backpressure, random lengths
        reset_all();
        cfg_fixed = 0; cfg_max = 6;
        start_job(0, next_len(), 20);
        start_job(1, next_len(), 20);
        run(400, 70, 60, 1'b0);
        drain(600, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pmu_sched.md
# pmu_sched

Job-level scheduler that shares one `pmu` parallel-multiply datapath between two requesters. Each requester submits a job of one or more operand beats. The scheduler arbitrates at job granularity (round-robin) and streams the owner's beats into the `pmu`. It tracks the fixed `pmu` latency with a tag pipeline and delivers tagged products through a credit-protected output FIFO with valid/ready backpressure.

## Interface
- `NUM_LANES`, 240, lanes per beat (must match the `pmu` instance)
- `DATA_WIDTH`, 16, operand width per lane
- `PMU_LAT`, 2, `pmu` cycles from operand capture edge to `P_flat` visible
- `LEN_W`, 8, job length field width
- `FIFO_DEPTH`, 4, result FIFO entries; must be ≥ `PMU_LAT`+2
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high; also drives the `pmu` instance `rst`
- `s_valid` in 2: per-requester beat valid
- `s_ready` out 2: per-requester beat accept; at most one bit high
- `s_len` in 2*`LEN_W`: per-requester job length minus 1; sampled only in the grant cycle
- `s_a0_flat`, `s_b0_flat` in `NUM_LANES`*`DATA_WIDTH`: requester 0 operands
- `s_a1_flat`, `s_b1_flat` in `NUM_LANES`*`DATA_WIDTH`: requester 1 operands
- `pmu_a_flat`, `pmu_b_flat` out `NUM_LANES`*`DATA_WIDTH`: to `pmu` `A_flat`/`B_flat`
- `pmu_p_flat` in `NUM_LANES`*(`DATA_WIDTH`+1): from `pmu` `P_flat`
- `m_valid` out 1: result valid
- `m_ready` in 1: result accept
- `m_p_flat` out `NUM_LANES`*(`DATA_WIDTH`+1): result lanes
- `m_id` out 1: requester that issued the beat
- `m_last` out 1: final beat of its job
- `busy` out 1: job owned or results outstanding

## Operation
- FSM states:
  - IDLE: if any `s_valid`, grant and go to BUSY. The grant cycle latches `owner` and `remaining` = `s_len[owner]` and does not accept a beat.
  - BUSY: issue beats from `owner`. On the beat with `remaining`==0, go to IDLE.
- Arbitration is round-robin. If both requesters are valid, grant the one not granted last. `last_grant` resets so that requester 0 wins the first tie.
- Ownership is held for the whole job:
  - `s_valid[owner]` low mid-job is a bubble; ownership is kept.
  - The other requester waits regardless of its `s_valid`.
- Issue condition: state BUSY, `s_valid[owner]`, and (`fifo_count` + `inflight`) < `FIFO_DEPTH`.
  - Both counts are registered values; a same-cycle FIFO pop does not free credit.
  - `s_ready[owner]` equals the issue condition. `s_ready` of the non-owner is always 0.
- The `pmu_a_flat`/`pmu_b_flat` mux always selects `owner` (requester 0 in IDLE after reset). Unissued cycles still feed the `pmu`; their products are discarded because the tag is invalid.
- Tag pipeline: `PMU_LAT` registers of {valid, id, last}. A stage is loaded on issue, with `last` = (`remaining`==0). A valid tag at the final stage writes `pmu_p_flat` with its id/last into the FIFO.
- `inflight` = count of valid tag stages.
- Products are the low `DATA_WIDTH`+1 bits of the unsigned lane product, as produced by the `pmu`; the scheduler does not modify them.
- Output FIFO: registered, not fall-through, in-order. `m_valid` = non-empty; pop on `m_valid`&&`m_ready`. A push and a pop in the same cycle are both performed.
- `busy` = (state BUSY) || `inflight`≠0 || `fifo_count`≠0.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `m_id`=0, `m_last`=0, `m_p_flat`=0, `busy`=0, state IDLE, all tags invalid, FIFO empty.
- Latency: a beat accepted in cycle t is pushed at the end of cycle t+`PMU_LAT`, so `m_valid` is first high in cycle t+`PMU_LAT`+1 (3 at default).
- Throughput: with `m_ready` held 1, one beat per cycle in BUSY. There is one idle cycle between jobs (the grant cycle).
- FIFO never overflows: the credit check guarantees space for every in-flight beat. If `m_ready`=0, issue stops once `fifo_count`+`inflight`=`FIFO_DEPTH`.
- Reset mid-operation: jobs, tags and FIFO contents are dropped, there is no partial `m_last`, and the next arbitration follows the post-reset `last_grant`.
- `s_len` changes after the grant cycle are ignored. `s_len`=0 is a 1-beat job; `s_len`=2^`LEN_W`-1 gives 256 beats at default.

## Test plan
- Req0 job `s_len`=2, all lanes A=3 B=5, `m_ready`=1:
  - `s_ready[0]` is high in cycles 1–3 after grant.
  - `m_valid` is high 3 cycles after each accept, with lanes=15, `m_id`=0, and `m_last` on the 3rd beat only.
- Lane A=0xFFFF, B=0xFFFF -> lane result 0x00001 (17-bit truncation). A=0x8000, B=2 -> 0x10000.
- Both `s_valid` high from reset, each `s_len`=1:
  - The job order is req0, req1, req0, req1.
  - `m_id` sequence is 0,0,1,1,0,0,…, with one gap cycle between jobs.
- `m_ready`=0, req1 job `s_len`=9:
  - Exactly 4 beats are accepted, then `s_ready`=0.
  - Raising `m_ready` drains all 10 results in order with no loss or duplication.
- `s_valid[0]` drops for 3 cycles mid-job while `s_valid[1]`=1 -> req1 is not granted until req0's last beat. Results are contiguous in beat order.
- `rst` asserted for 1 cycle with 2 beats in flight and 2 in the FIFO -> next cycle `m_valid`=0 and `busy`=0. A new job behaves exactly like the first test.
